// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The optional illegal-opcode halt is enabled by the macro CTRL_ILLEGAL_HALT_EN.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_LUIX, S_ALUWB, S_JAL, S_JALRADR, S_JALR,
    S_BRANCH, S_HALT
  } state_t;

  // Which kind of ALU operation the current state needs.
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_RESULT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RD1      = 2'b10;
  localparam logic [1:0] SRCA_ZERO     = 2'b11;
  localparam logic [1:0] SRCB_WDATA    = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  // Branch resolution from the flags of rs1 - rs2.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero, input logic negative,
                                        input logic carryout, input logic overflow);
    logic taken;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = negative ^ overflow;
      3'b101:  taken = !(negative ^ overflow);
      3'b110:  taken = !carryout;
      3'b111:  taken = carryout;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decode from the state class and the instruction function fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_ctrl
);

  // R and I types share the funct3 map; only R-type may turn funct3=000 into SUB.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_cls)
      CLS_ADD: o_alu_ctrl = ALU_ADD;
      CLS_SUB: o_alu_ctrl = ALU_SUB;
      default: begin
        case (i_funct3)
          3'b000:  o_alu_ctrl = (i_cls == CLS_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b011:  o_alu_ctrl = ALU_SLTU;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b101:  o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the RV32I datapath.
// Define CTRL_ILLEGAL_HALT_EN to trap unknown opcodes into HALT with a sticky flag;
// otherwise unknown opcodes retire as NOPs.
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | rs1+imm for load/store
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// LUIX     | 0+imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= ALUOut, ALU computes OldPC+4
// JALRADR  | rs1+imm
// JALR     | PC <= ALUOut, ALU computes OldPC+4
// BRANCH   | compare rs1-rs2, PC <= ALUOut if taken
// HALT     | stopped until reset
module mc_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        zero,
  input  logic        negative,
  input  logic        carryout,
  input  logic        overflow,
  output logic        pc_write,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ALUSrca,
  output logic [1:0]  ALUSrcb,
  output logic        RegWrite,
  output logic        instr_done,
  output logic        illegal
);

  state_t     r_state, w_next;
  alu_cls_t   w_cls;
  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write, w_done;
  logic [1:0] w_result_src, w_srca, w_srcb;
  logic [3:0] w_alu_ctrl;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_instr;

  assign w_opcode       = Instr[6:0];
  assign w_funct3       = Instr[14:12];
  assign w_unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  alu_decoder u_alu_decoder (
    .i_cls      (w_cls),
    .i_funct3   (w_funct3),
    .i_funct7_5 (Instr[30]),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

`ifdef CTRL_ILLEGAL_HALT_EN
  logic r_illegal, w_set_illegal;

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end
`endif

  // Next-state and datapath controls decoded from the current state.
  always_comb begin
    w_next       = r_state;
    w_cls        = CLS_ADD;
    w_pc_write   = 1'b0;
    w_adr_src    = ADR_PC;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_done       = 1'b0;
    w_result_src = RES_ALUOUT;
    w_srca       = SRCA_PC;
    w_srcb       = SRCB_WDATA;
`ifdef CTRL_ILLEGAL_HALT_EN
    w_set_illegal = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_srcb       = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_pc_write   = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_LUI:            w_next = S_LUIX;
          OP_AUIPC:          w_next = S_ALUWB;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALRADR;
          OP_BRANCH:         w_next = S_BRANCH;
          default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
`else
            w_next = S_FETCH;
            w_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR, S_JALRADR: begin
        w_srca = SRCA_RD1;
        w_srcb = SRCB_IMM;
        if (r_state == S_JALRADR)      w_next = S_JALR;
        else if (w_opcode == OP_LOAD)  w_next = S_MEMREAD;
        else                           w_next = S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = ADR_RESULT;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = ADR_RESULT;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXECR: begin
        w_srca = SRCA_RD1;
        w_cls  = CLS_R;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_srca = SRCA_RD1;
        w_srcb = SRCB_IMM;
        w_cls  = CLS_I;
        w_next = S_ALUWB;
      end
      S_LUIX: begin
        w_srca = SRCA_ZERO;
        w_srcb = SRCB_IMM;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL, S_JALR: begin
        w_srca     = SRCA_OLDPC;
        w_srcb     = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BRANCH: begin
        w_srca     = SRCA_RD1;
        w_cls      = CLS_SUB;
        w_pc_write = branch_taken(w_funct3, zero, negative, carryout, overflow);
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Every control is held low while reset is asserted, independent of the clock.
  assign pc_write   = reset & w_pc_write;
  assign AdrSrc     = reset & w_adr_src;
  assign MemWrite   = reset & w_mem_write;
  assign IRWrite    = reset & w_ir_write;
  assign RegWrite   = reset & w_reg_write;
  assign instr_done = reset & w_done;
  assign ResultSrc  = reset ? w_result_src : 2'b00;
  assign ALUControl = reset ? w_alu_ctrl   : 4'b0000;
  assign ALUSrca    = reset ? w_srca       : 2'b00;
  assign ALUSrcb    = reset ? w_srcb       : 2'b00;
`ifdef CTRL_ILLEGAL_HALT_EN
  assign illegal    = reset & r_illegal;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control state machine for the 32-bit RV32I core: decodes the latched instruction and sequences the shared datapath over consecutive cycles. Memory, register file, ALU, PC, and the non-architectural registers are all reused this way. Drives every mux select and write enable of the datapath, samples the ALU flags for branch resolution, and flags illegal opcodes. Sits beside the datapath inside the top-level CPU.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low = in reset
- Instr  in  32  instruction register output
- zero, negative, carryout, overflow  in  1 each  ALU flags of the current cycle
- pc_write  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUControl  out  4  ALU operation code
- ALUSrca  out  2  00 = PC, 01 = OldPC, 10 = RD1_A, 11 = zero
- ALUSrcb  out  2  00 = WriteData, 01 = ImmExt, 10 = 4
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States and outputs. Unlisted outputs are 0; ALU add = ADD.
  - FETCH: AdrSrc0, IRWrite, ALUSrca00, ALUSrcb10, ADD, ResultSrc10, pc_write.
  - DECODE: ALUSrca01, ALUSrcb01, ADD. ALUOut becomes OldPC+imm.
  - MEMADR / JALRADR: ALUSrca10, ALUSrcb01, ADD.
  - MEMREAD: ResultSrc00, AdrSrc1.
  - MEMWB: ResultSrc01, RegWrite, instr_done.
  - MEMWRITE: ResultSrc00, AdrSrc1, MemWrite, instr_done.
  - EXECR: ALUSrca10, ALUSrcb00, decoded op.
  - EXECI: ALUSrca10, ALUSrcb01, decoded op.
  - LUIX: ALUSrca11, ALUSrcb01, ADD.
  - ALUWB: ResultSrc00, RegWrite, instr_done.
  - JAL / JALR: ALUSrca01, ALUSrcb10, ADD, ResultSrc00, pc_write.
  - BRANCH: ALUSrca10, ALUSrcb00, SUB, ResultSrc00, pc_write = taken, instr_done.
  - HALT: all outputs 0.
- Transitions: FETCH→DECODE always. From DECODE by opcode:
  - 0000011 → MEMADR→MEMREAD→MEMWB→FETCH.
  - 0100011 → MEMADR→MEMWRITE→FETCH.
  - 0110011 → EXECR→ALUWB.
  - 0010011 → EXECI→ALUWB.
  - 0110111 → LUIX→ALUWB.
  - 0010111 → ALUWB (DECODE already produced OldPC+imm).
  - 1101111 → JAL→ALUWB.
  - 1100111 → JALRADR→JALR→ALUWB.
  - 1100011 → BRANCH→FETCH.
  - ALUWB→FETCH.
- Loads and stores are word-only; funct3 is ignored.
- ALU decode (sub-module):
  - R-type: funct3 plus funct7[5] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - I-type: funct7[5] is honoured only for funct3 = 101 (SRAI); ADDI never becomes SUB.
- Branch taken, by funct3:
  - 000: zero
  - 001: !zero
  - 100: negative^overflow
  - 101: !(negative^overflow)
  - 110: !carryout
  - 111: carryout
  - 010 and 011: never taken.

## Timing
- Cycles per instruction: AUIPC 3, branch 3, R/I/LUI/JAL/store 4, load/JALR 5.
- State register updates on rising clk. Outputs are combinational from state, plus Instr in EXECR/EXECI/BRANCH, plus flags in BRANCH.
- Reset low (asynchronous):
  - state = FETCH, illegal = 0.
  - While reset is low, every output is forced to 0.
  - First FETCH is the first rising edge after reset goes high.
- Reset asserted mid-instruction aborts it immediately; no partial write enable survives the assertion edge.
- Instr changes only in FETCH, so decode inputs are stable from DECODE to the end of the instruction.

## Configuration
- CTRL_ILLEGAL_HALT_EN defined:
  - An unrecognised opcode in DECODE sets illegal and moves to HALT.
  - HALT persists until reset.
- Undefined:
  - An unrecognised opcode is a NOP: DECODE→FETCH with instr_done.
  - illegal is tied to 0.

## Structure
- Package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - ALU op codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001;
  - mux select encodings.
- Sub-module alu_decoder: combinational map of (state class, funct3, funct7[5]) to ALUControl.

## Test plan
- Reset low for 3 cycles, then high → all outputs 0 during reset; FETCH on the first edge with pc_write=1, IRWrite=1, ALUSrcb=10.
- Instr=0x00312023 (sw x3,0(x2)) → states FETCH, DECODE, MEMADR, MEMWRITE; MemWrite=1 and AdrSrc=1 only in cycle 4; instr_done in cycle 4.
- Instr=0x40208033 (sub x0,x1,x2) → EXECR shows ALUControl=0001, then ALUWB with RegWrite=1; 4 cycles total.
- Instr=0x00208463 (beq) in BRANCH with zero=1 → pc_write=1; repeat with zero=0 → pc_write=0; next state FETCH in both cases.
- Instr=0x000080E7 (jalr x1,0(x1)) → 5 cycles; pc_write=1 in JALR; RegWrite=1 in ALUWB. Assert reset during JALRADR → outputs 0 at once, FETCH after release.
- Instr=0xFFFFFFFF → with CTRL_ILLEGAL_HALT_EN: illegal=1 and HALT held for 10 cycles; without it: returns to FETCH on cycle 3.
